// File: rtl/seg7_scroll_driver.sv
// seg7_scroll_driver: scrolls a buffered segment-pattern message across the
// six-digit HEX bank (HEX5..HEX0) by issuing six Data/Addr/Sel writes per tick.
// Optional macro SEG7_SCROLL_DIR_EN adds a Dir input (1 = text moves right).
//
// state | meaning
// IDLE  | waiting for a scroll tick; latches length/direction at frame start
// WRITE | six registered writes to HEX5..HEX0, k counts 1..6
// ADV   | moves the window start by one character, then back to IDLE
module seg7_scroll_driver #(
  parameter int MSG_LEN  = 16,
  parameter int AW       = 4,
  parameter int TICK_DIV = 25000000
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [6:0]    WrData,
  input  logic [AW:0]   Len,
  input  logic          Run,
`ifdef SEG7_SCROLL_DIR_EN
  input  logic          Dir,
`endif
  output logic [6:0]    Data,
  output logic [2:0]    Addr,
  output logic          Sel,
  output logic          Busy,
  output logic [AW-1:0] Pos
);

  localparam int            CW     = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TC     = CW'(TICK_DIV - 1);
  localparam logic [AW:0]   MAXLEN = (AW+1)'(MSG_LEN);

  typedef enum logic [1:0] {IDLE, WRITE, ADV} state_t;

  logic [6:0]    mem [MSG_LEN];
  logic          run_q;
  logic [CW-1:0] cnt;
  logic          start_tick;
  logic          tick;
  state_t        state;
  logic [2:0]    k;
  logic [AW:0]   len_q;
  logic [AW-1:0] ridx;
  logic [AW:0]   len_eff;
  logic [AW-1:0] pos_red;
`ifdef SEG7_SCROLL_DIR_EN
  logic          dir_q;
`endif

  function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] i, input logic [AW:0] l);
    return (((AW+1)'(i) + 1'b1) == l) ? '0 : i + 1'b1;
  endfunction

`ifdef SEG7_SCROLL_DIR_EN
  function automatic logic [AW-1:0] dec_wrap(input logic [AW-1:0] i, input logic [AW:0] l);
    return (i == '0) ? AW'(l - 1'b1) : i - 1'b1;
  endfunction
`endif

  // Tick decode, clamped length and window start folded into the new length.
  always_comb begin
    start_tick = Run && !run_q;
    tick       = Run && (cnt == TC);
    len_eff    = (Len > MAXLEN) ? MAXLEN : Len;
    pos_red    = Pos;
    if ((len_eff != '0) && ({1'b0, Pos} >= len_eff))
      pos_red = AW'({1'b0, Pos} % len_eff);
  end

  // Scroll timer; a start tick restarts the period so every frame is TICK_DIV apart.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      run_q <= 1'b0;
      cnt   <= '0;
    end else begin
      run_q <= Run;
      if (!Run || start_tick || tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  // Message buffer; reads elsewhere see the pre-write contents.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < MSG_LEN; i++)
        mem[i] <= '0;
    end else if (WrEn) begin
      mem[WrAddr] <= WrData;
    end
  end

  // Frame sequencer with registered HEX-bank outputs.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
      k     <= '0;
      len_q <= '0;
      ridx  <= '0;
      Data  <= '0;
      Addr  <= '0;
      Sel   <= 1'b0;
      Busy  <= 1'b0;
      Pos   <= '0;
`ifdef SEG7_SCROLL_DIR_EN
      dir_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Sel <= 1'b0;
          if (!Run) begin
            Pos <= '0;
          end else if ((tick || start_tick) && (len_eff != '0)) begin
            len_q <= len_eff;
            Pos   <= pos_red;
            Data  <= mem[pos_red];
            Addr  <= 3'd5;
            Sel   <= 1'b1;
            Busy  <= 1'b1;
            k     <= 3'd1;
            ridx  <= inc_wrap(pos_red, len_eff);
`ifdef SEG7_SCROLL_DIR_EN
            dir_q <= Dir;
`endif
            state <= WRITE;
          end
        end
        WRITE: begin
          if (k == 3'd6) begin
            Sel   <= 1'b0;
            state <= ADV;
          end else begin
            Data <= mem[ridx];
            Addr <= 3'd5 - k;
            ridx <= inc_wrap(ridx, len_q);
            k    <= k + 1'b1;
          end
        end
        ADV: begin
          Busy  <= 1'b0;
          state <= IDLE;
          if (!Run)
            Pos <= '0;
`ifdef SEG7_SCROLL_DIR_EN
          else if (dir_q)
            Pos <= dec_wrap(Pos, len_q);
`endif
          else
            Pos <= inc_wrap(Pos, len_q);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scroll_driver.sv
// Testbench for seg7_scroll_driver: random buffer contents and lengths checked
// against a message/window model (array + modulo arithmetic).
`timescale 1ns/1ps
module tb_seg7_scroll_driver;
  localparam int MSG_LEN  = 16;
  localparam int AW       = 4;
  localparam int TICK_DIV = 10;
  localparam int WAIT_MAX = 3 * TICK_DIV;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [6:0]    WrData;
  logic [AW:0]   Len;
  logic          Run;
  logic [6:0]    Data;
  logic [2:0]    Addr;
  logic          Sel;
  logic          Busy;
  logic [AW-1:0] Pos;
`ifdef SEG7_SCROLL_DIR_EN
  logic          Dir;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [6:0] mbuf [MSG_LEN];
  int mpos = 0;
  int mdir = 0;

  seg7_scroll_driver #(.MSG_LEN(MSG_LEN), .AW(AW), .TICK_DIV(TICK_DIV)) dut (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Len(Len), .Run(Run),
`ifdef SEG7_SCROLL_DIR_EN
    .Dir(Dir),
`endif
    .Data(Data), .Addr(Addr), .Sel(Sel), .Busy(Busy), .Pos(Pos)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic write_entry(input int a, input logic [6:0] d);
    WrEn = 1'b1; WrAddr = AW'(a); WrData = d;
    @(negedge Clock);
    WrEn = 1'b0;
    mbuf[a] = d;
  endtask

  function automatic int model_len();
    return (int'(Len) > MSG_LEN) ? MSG_LEN : int'(Len);
  endfunction

  task automatic test_reset();
    int t;
    int L;
    Resetn = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0; Len = 5'd16; Run = 1'b0;
    repeat (3) @(negedge Clock);
    checks++; if (Sel !== 1'b0)  begin errors++; $display("FAIL reset_sel got %b want 0", Sel); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Pos !== '0)    begin errors++; $display("FAIL reset_pos got %0d want 0", Pos); end
    checks++; if (Data !== '0 || Addr !== '0) begin errors++; $display("FAIL reset_data_addr got %h/%0d want 0/0", Data, Addr); end
    Resetn = 1'b1;
    for (int i = 0; i < MSG_LEN; i++) write_entry(i, 7'($urandom_range(1, 127)));
    Run = 1'b1;
    t = 0;
    while (Sel !== 1'b1 && t < WAIT_MAX) begin @(negedge Clock); t++; end
    checks++; if (Sel !== 1'b1) begin errors++; $display("FAIL reset_pre_frame Sel got %b want 1", Sel); end
    repeat (2) @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    checks++; if (Sel !== 1'b0 || Busy !== 1'b0 || Pos !== '0)
      begin errors++; $display("FAIL reset_mid_frame Sel/Busy/Pos got %b/%b/%0d want 0/0/0", Sel, Busy, Pos); end
    @(negedge Clock);
    for (int i = 0; i < MSG_LEN; i++) mbuf[i] = '0;
    mpos = 0;
    Resetn = 1'b1;
    for (int f = 0; f < 11; f++) begin
      t = 0;
      while (Sel !== 1'b1 && t < WAIT_MAX) begin @(negedge Clock); t++; end
      checks++; if (Sel !== 1'b1) begin errors++; $display("FAIL reset_frame_start f=%0d Sel got %b want 1", f, Sel); end
      L = model_len();
      mpos = mpos % L;
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (Sel !== 1'b1 || Addr !== 3'(5 - k) || Data !== mbuf[(mpos + k) % L]) begin
          errors++;
          $display("FAIL reset_blank f=%0d k=%0d got Sel=%b Addr=%0d Data=%h want 1/%0d/%h",
                   f, k, Sel, Addr, Data, 5 - k, mbuf[(mpos + k) % L]);
        end
        @(negedge Clock);
      end
      @(negedge Clock);
      mpos = (mpos + 1) % L;
      checks++; if (Pos !== AW'(mpos)) begin errors++; $display("FAIL reset_pos_adv f=%0d got %0d want %0d", f, Pos, mpos); end
    end
    Run = 1'b0;
    repeat (2) @(negedge Clock);
    mpos = 0;
  endtask

  task automatic test_scroll();
    int t;
    int L;
    int last;
    for (int i = 0; i < MSG_LEN; i++) write_entry(i, 7'(i + 1));
    Len = 5'd16;
    mpos = 0;
    Run = 1'b1;
    @(negedge Clock);
    last = 0;
    for (int f = 0; f < 3; f++) begin
      t = 0;
      while (Sel !== 1'b1 && t < WAIT_MAX) begin @(negedge Clock); t++; end
      checks++; if (Sel !== 1'b1) begin errors++; $display("FAIL scroll_start f=%0d Sel got %b want 1", f, Sel); end
      if (f == 0) begin
        checks++; if (t != 0) begin errors++; $display("FAIL scroll_latency got %0d extra cycles want 0", t); end
      end else begin
        checks++; if (cyc - last != TICK_DIV) begin errors++; $display("FAIL scroll_period got %0d want %0d", cyc - last, TICK_DIV); end
      end
      last = cyc;
      L = model_len();
      mpos = mpos % L;
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (Sel !== 1'b1 || Addr !== 3'(5 - k) || Data !== mbuf[(mpos + k) % L]) begin
          errors++;
          $display("FAIL scroll_write f=%0d k=%0d got Sel=%b Addr=%0d Data=%h want 1/%0d/%h",
                   f, k, Sel, Addr, Data, 5 - k, mbuf[(mpos + k) % L]);
        end
        @(negedge Clock);
      end
      checks++; if (Sel !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL scroll_adv got Sel=%b Busy=%b want 0/1", Sel, Busy); end
      @(negedge Clock);
      mpos = (mpos + 1) % L;
      checks++; if (Busy !== 1'b0 || Pos !== AW'(mpos)) begin errors++; $display("FAIL scroll_pos f=%0d got Busy=%b Pos=%0d want 0/%0d", f, Busy, Pos, mpos); end
    end
    Run = 1'b0;
    @(negedge Clock);
    mpos = 0;
    checks++; if (Pos !== '0) begin errors++; $display("FAIL scroll_stop_pos got %0d want 0", Pos); end
  endtask

  task automatic test_short_len();
    int t;
    int L;
    write_entry(0, 7'h3F);
    write_entry(1, 7'h06);
    write_entry(2, 7'h5B);
    Len = 5'd3;
    mpos = 0;
    Run = 1'b1;
    for (int f = 0; f < 3; f++) begin
      t = 0;
      while (Sel !== 1'b1 && t < WAIT_MAX) begin @(negedge Clock); t++; end
      checks++; if (Sel !== 1'b1) begin errors++; $display("FAIL short_start f=%0d Sel got %b want 1", f, Sel); end
      L = model_len();
      mpos = mpos % L;
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (Sel !== 1'b1 || Addr !== 3'(5 - k) || Data !== mbuf[(mpos + k) % L]) begin
          errors++;
          $display("FAIL short_write f=%0d k=%0d got Sel=%b Addr=%0d Data=%h want 1/%0d/%h",
                   f, k, Sel, Addr, Data, 5 - k, mbuf[(mpos + k) % L]);
        end
        @(negedge Clock);
      end
      @(negedge Clock);
      mpos = (mpos + 1) % L;
      checks++; if (Pos !== AW'(mpos)) begin errors++; $display("FAIL short_pos f=%0d got %0d want %0d", f, Pos, mpos); end
    end
    Run = 1'b0;
    repeat (2) @(negedge Clock);
    mpos = 0;
  endtask

  task automatic test_len_zero();
    bit seen = 0;
    Len = '0;
    Run = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (Sel === 1'b1) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL len_zero_sel got 1 want 0"); end
    checks++; if (Pos !== '0) begin errors++; $display("FAIL len_zero_pos got %0d want 0", Pos); end
    Run = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_run_drop();
    int t;
    bit seen = 0;
    for (int i = 0; i < MSG_LEN; i++) write_entry(i, 7'($urandom_range(0, 127)));
    Len = 5'd16;
    mpos = 0;
    Run = 1'b1;
    t = 0;
    while (Sel !== 1'b1 && t < WAIT_MAX) begin @(negedge Clock); t++; end
    checks++; if (Sel !== 1'b1) begin errors++; $display("FAIL drop_start Sel got %b want 1", Sel); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (Sel !== 1'b1 || Addr !== 3'(5 - k) || Data !== mbuf[k]) begin
        errors++;
        $display("FAIL drop_write k=%0d got Sel=%b Addr=%0d Data=%h want 1/%0d/%h", k, Sel, Addr, Data, 5 - k, mbuf[k]);
      end
      if (k == 2) Run = 1'b0;
      @(negedge Clock);
    end
    checks++; if (Sel !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL drop_adv got Sel=%b Busy=%b want 0/1", Sel, Busy); end
    @(negedge Clock);
    checks++; if (Pos !== '0 || Busy !== 1'b0) begin errors++; $display("FAIL drop_pos got Pos=%0d Busy=%b want 0/0", Pos, Busy); end
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Sel === 1'b1) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL drop_quiet Sel got 1 want 0"); end
  endtask

  task automatic test_random();
    int t;
    int L;
    int last;
    for (int i = 0; i < MSG_LEN; i++) write_entry(i, 7'($urandom_range(0, 127)));
    Len = 5'($urandom_range(1, 31));
    mpos = 0;
    Run = 1'b1;
    last = 0;
    for (int f = 0; f < 18; f++) begin
      t = 0;
      while (Sel !== 1'b1 && t < WAIT_MAX) begin @(negedge Clock); t++; end
      checks++; if (Sel !== 1'b1) begin errors++; $display("FAIL rand_start f=%0d Sel got %b want 1", f, Sel); end
      if (f > 0) begin
        checks++; if (cyc - last != TICK_DIV) begin errors++; $display("FAIL rand_period f=%0d got %0d want %0d", f, cyc - last, TICK_DIV); end
      end
      last = cyc;
      L = model_len();
      mpos = mpos % L;
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (Sel !== 1'b1 || Addr !== 3'(5 - k) || Data !== mbuf[(mpos + k) % L]) begin
          errors++;
          $display("FAIL rand_write f=%0d L=%0d k=%0d got Sel=%b Addr=%0d Data=%h want 1/%0d/%h",
                   f, L, k, Sel, Addr, Data, 5 - k, mbuf[(mpos + k) % L]);
        end
        @(negedge Clock);
      end
      @(negedge Clock);
      mpos = (mdir != 0) ? (mpos + L - 1) % L : (mpos + 1) % L;
      checks++; if (Pos !== AW'(mpos)) begin errors++; $display("FAIL rand_pos f=%0d L=%0d got %0d want %0d", f, L, Pos, mpos); end
      if ($urandom_range(0, 1) == 1) Len = 5'($urandom_range(1, 31));
`ifdef SEG7_SCROLL_DIR_EN
      mdir = int'($urandom_range(0, 1));
      Dir  = mdir[0];
`endif
      write_entry(int'($urandom_range(0, MSG_LEN - 1)), 7'($urandom_range(0, 127)));
    end
    Run = 1'b0;
    repeat (2) @(negedge Clock);
    mpos = 0;
    mdir = 0;
`ifdef SEG7_SCROLL_DIR_EN
    Dir = 1'b0;
`endif
  endtask

`ifdef SEG7_SCROLL_DIR_EN
  task automatic test_dir();
    int t;
    int L;
    for (int i = 0; i < MSG_LEN; i++) write_entry(i, 7'($urandom_range(0, 127)));
    Len = 5'd16;
    Dir = 1'b1;
    mdir = 1;
    mpos = 0;
    Run = 1'b1;
    for (int f = 0; f < 2; f++) begin
      t = 0;
      while (Sel !== 1'b1 && t < WAIT_MAX) begin @(negedge Clock); t++; end
      checks++; if (Sel !== 1'b1) begin errors++; $display("FAIL dir_start f=%0d Sel got %b want 1", f, Sel); end
      L = model_len();
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (Sel !== 1'b1 || Addr !== 3'(5 - k) || Data !== mbuf[(mpos + k) % L]) begin
          errors++;
          $display("FAIL dir_write f=%0d k=%0d got Addr=%0d Data=%h want %0d/%h", f, k, Addr, Data, 5 - k, mbuf[(mpos + k) % L]);
        end
        @(negedge Clock);
      end
      @(negedge Clock);
      mpos = (mpos + L - 1) % L;
      checks++; if (Pos !== AW'(mpos)) begin errors++; $display("FAIL dir_pos f=%0d got %0d want %0d", f, Pos, mpos); end
    end
    Run = 1'b0;
    Dir = 1'b0;
    mdir = 0;
    repeat (2) @(negedge Clock);
    mpos = 0;
  endtask
`endif

  initial begin
`ifdef SEG7_SCROLL_DIR_EN
    Dir = 1'b0;
`endif
    test_reset();
    test_scroll();
    test_short_len();
    test_len_zero();
    test_run_drop();
    test_random();
`ifdef SEG7_SCROLL_DIR_EN
    test_dir();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scroll_driver.md
Name: seg7_scroll_driver

Overview:
- Hardware message scroller that sits directly upstream of the six-digit HEX register bank.
- Holds a processor-loaded buffer of 7-bit segment patterns (active-high, bit 0 = segment a).
- On each scroll tick it emits six consecutive single-cycle writes (Data/Addr/Sel) that paint a window of the message onto HEX5..HEX0, then advances the window by one character.
- Lets the message scroll without processor involvement.

Parameters:
- MSG_LEN, 16, depth of the message buffer (entries); power of 2, range 8..64.
- AW, 4, buffer address width; equals log2(MSG_LEN).
- TICK_DIV, 25000000, clocks per scroll step; must be >= 8.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Resetn  in  1  synchronous active-low reset.
- WrEn  in  1  buffer write strobe.
- WrAddr  in  AW  buffer entry to write.
- WrData  in  7  segment pattern to store.
- Len  in  AW+1  active message length; sampled at frame start.
- Run  in  1  scrolling enable.
- Data  out  7  segment pattern to the HEX bank.
- Addr  out  3  HEX digit index to the HEX bank (0..5).
- Sel  out  1  write strobe to the HEX bank.
- Busy  out  1  high while a frame is being emitted.
- Pos  out  AW  current window start index.

Behaviour:
- Reset, synchronous, while Resetn=0 at posedge:
  - all buffer entries = 7'h00 (blank);
  - Data=0, Addr=0, Sel=0, Busy=0, Pos=0;
  - tick counter = 0; FSM = IDLE.
- Buffer write: WrEn=1 stores WrData at WrAddr at posedge.
  - Reads use registered contents, so a same-cycle write to an entry being emitted yields the old value.
  - The write is visible from the next cycle.
- Tick counter:
  - Run=0: counter held at 0, Pos held at 0.
  - Run=1: counter counts 0..TICK_DIV-1 and wraps; tick = 1 at terminal count.
- Start tick: a Run 0->1 transition (Run registered internally) generates an immediate start tick, so the first frame does not wait TICK_DIV cycles.
- FSM states:
  - IDLE: on tick (or start tick), latch L = min(Len, MSG_LEN).
    - If L=0: stay in IDLE, no writes, Pos unchanged.
    - Else: go to WRITE with k=0.
  - WRITE: six cycles, k=0..5. In each cycle k the registered outputs are:
    - Sel=1;
    - Addr=5-k;
    - Data=buf[(Pos+k) mod L].
    - After k=5 go to ADV.
  - ADV: one cycle, Sel=0, Pos <= (Pos+1) mod L, then go to IDLE.
- Timing:
  - Outputs are registered: a tick at cycle T gives Sel=1 during cycles T+1..T+6; Pos updates at the end of T+7.
  - Busy=1 during WRITE and ADV (T+1..T+7).
- Wrap-around:
  - L<6: window indices wrap modulo L, repeating characters across digits.
  - Pos only ever takes values 0..L-1.
  - If Len shrinks so that Pos >= new L, Pos is reduced mod L at the next frame start before emitting.
- Run deasserted mid-frame: the frame completes (all 6 writes plus ADV), then Pos is forced to 0 and the counter cleared.
- Reset mid-frame: Sel=0 from the next cycle; no partial frame resumes.
- No tick can occur while Busy=1 (TICK_DIV>=8); no pending-tick storage.
- When not writing: Sel=0 and Data/Addr hold their last values.

Optional Feature:
- Macro: SEG7_SCROLL_DIR_EN.
- Defined:
  - Adds input port Dir (1 bit), sampled at frame start.
  - Dir=0: Pos advances +1 mod L (text moves left).
  - Dir=1: Pos advances -1 mod L, i.e. from 0 to L-1 (text moves right).
- Undefined: no Dir port; always +1.

Test Plan:
- Reset with buffer preloaded and Run=1 -> cycle after Resetn deasserts: Sel=0, Pos=0, all buffer entries read 0.
- Load buf[i]=i+1 for i=0..15, Len=16, TICK_DIV=10, raise Run -> (Addr,Data) = (5,1),(4,2),(3,3),(2,4),(1,5),(0,6) on six consecutive cycles starting one cycle after the start tick; Pos=1 afterwards; next frame after 10 clocks shows 2..7.
- Len=3, buf={0x3F,0x06,0x5B}, Pos=0 -> Data sequence 3F,06,5B,3F,06,5B; after 3 frames Pos returns to 0.
- Len=0 with Run=1 -> Sel never asserts over 50 cycles; Pos stays 0.
- Drop Run during write k=2 -> remaining writes k=3..5 still issued; then Pos=0 and no further Sel.
- With SEG7_SCROLL_DIR_EN, Dir=1, Len=16, Pos=0 -> after one frame Pos=15; next frame Addr5 shows buf[15].
